// File: rtl/int_root_unit_if.sv
// int_root_unit_if: start/ready handshake bundle for the integer root unit
// master drives start/mode/x_in; slave returns root/rem/ready/busy.
interface int_root_unit_if #(parameter int WIDTH = 16);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] root;
  logic [WIDTH-1:0] rem;
  logic             ready;
  logic             busy;
  modport master (output start, mode, x_in, input root, rem, ready, busy);
  modport slave  (input start, mode, x_in, output root, rem, ready, busy);
endinterface

// File: rtl/int_root_unit.sv
// int_root_unit: digit-by-digit integer square/cube root with remainder
// Ports: clk; rst (sync, active-low); bus (slave): start, mode (0 sqrt, 1 cbrt), x_in in;
//        root, rem, ready (one-cycle pulse), busy out.
module int_root_unit #(parameter int WIDTH = 16) (
  input logic            clk,
  input logic            rst,
  int_root_unit_if.slave bus
);
  localparam int N2 = (WIDTH + 1) / 2;
  localparam int N3 = (WIDTH + 2) / 3;
  localparam int BW = 2 * WIDTH + 2;
  localparam logic [5:0] S2 = 6'(2 * (N2 - 1));
  localparam logic [5:0] S3 = 6'(3 * (N3 - 1));
  localparam logic [BW-1:0] ONE = BW'(1);
  typedef enum logic [1:0] {IDLE, TRIAL, TEST, DONE} state_t;
  state_t state_q;
  logic md_q, ready_q, busy_q;
  logic [WIDTH-1:0] x_q, y_q, root_q, rem_q;
  logic [BW-1:0] ysq_q, b_q, y_w, x_w, t_w, b_d;
  logic [5:0] s_q, cnt_q, step;
  // Trial values use the pre-doubling y/ysq: 4y+1 for square, 3*(4ysq+2y)+1 for cube,
  // formed wide enough that the shift by the top s never wraps.
  always_comb begin
    y_w = BW'(y_q);
    x_w = BW'(x_q);
    t_w = (ysq_q << 2) + (y_w << 1);
    b_d = (md_q ? (t_w << 1) + t_w + ONE : (y_w << 2) + ONE) << s_q;
    step = md_q ? 6'd3 : 6'd2;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      md_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      ysq_q   <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (bus.start) begin
            x_q     <= bus.x_in;
            md_q    <= bus.mode;
            y_q     <= '0;
            ysq_q   <= '0;
            s_q     <= bus.mode ? S3 : S2;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= TRIAL;
          end
        end
        TRIAL: begin
          y_q     <= y_q << 1;
          ysq_q   <= ysq_q << 2;
          b_q     <= b_d;
          state_q <= TEST;
        end
        TEST: begin
          // y here is already doubled, so ysq gains 2y+1 when the digit is 1
          if (x_w >= b_q) begin
            x_q   <= x_q - b_q[WIDTH-1:0];
            y_q   <= y_q + WIDTH'(1);
            ysq_q <= ysq_q + {y_w[BW-2:0], 1'b1};
          end
          s_q     <= s_q >= step ? s_q - step : s_q;
          state_q <= s_q >= step ? TRIAL : DONE;
          cnt_q   <= cnt_q + 6'd1;
        end
        DONE: begin
          root_q  <= y_q;
          rem_q   <= x_q;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.root  = root_q;
  assign bus.rem   = rem_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_int_root_unit.sv
// tb_int_root_unit: self-checking bench for int_root_unit at WIDTH=16 and WIDTH=32
module tb_int_root_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int pass_n = 0;
  int tot_n = 0;
  always #5 clk = ~clk;
  int_root_unit_if #(.WIDTH(16)) b16 ();
  int_root_unit_if #(.WIDTH(32)) b32 ();
  int_root_unit #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  int_root_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  function automatic longint unsigned pw(input longint unsigned r, input int k);
    return k == 3 ? r * r * r : r * r;
  endfunction
  function automatic longint unsigned mroot(input longint unsigned x, input int k);
    longint unsigned lo = 0, hi = 65536, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (pw(mid, k) <= x) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction
  function automatic int lat_of(input int w, input logic m);
    return m ? 2 * ((w + 2) / 3) + 1 : 2 * ((w + 1) / 2) + 1;
  endfunction
  task automatic op16(input logic m, input logic [15:0] x, output int lat, output logic [15:0] r, output logic [15:0] rm);
    @(posedge clk); #1;
    b16.start = 1'b1; b16.mode = m; b16.x_in = x;
    @(posedge clk); #1;
    b16.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (b16.ready) begin lat = c; break; end
    end
    r = b16.root; rm = b16.rem;
  endtask
  task automatic op32(input logic m, input logic [31:0] x, output int lat, output logic [31:0] r, output logic [31:0] rm);
    @(posedge clk); #1;
    b32.start = 1'b1; b32.mode = m; b32.x_in = x;
    @(posedge clk); #1;
    b32.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (b32.ready) begin lat = c; break; end
    end
    r = b32.root; rm = b32.rem;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    b16.start = 1'b1; b16.mode = 1'b0; b16.x_in = 16'd100;
    b32.start = 1'b1; b32.mode = 1'b1; b32.x_in = 32'd1000;
    repeat (3) @(posedge clk);
    #1;
    tot_n++;
    if ({b16.root, b16.rem, b16.ready, b16.busy} !== 34'd0) $display("FAIL reset16: got root=%0d rem=%0d ready=%b busy=%b want 0", b16.root, b16.rem, b16.ready, b16.busy);
    else pass_n++;
    tot_n++;
    if ({b32.root, b32.rem, b32.ready, b32.busy} !== 66'd0) $display("FAIL reset32: got root=%0d rem=%0d ready=%b busy=%b want 0", b32.root, b32.rem, b32.ready, b32.busy);
    else pass_n++;
    b16.start = 1'b0; b32.start = 1'b0;
    rst = 1'b1;
  endtask
  task automatic test_basic16();
    logic [15:0] xs [5] = '{16'd27, 16'd65535, 16'd9, 16'd65535, 16'd0};
    logic ms [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int lat, k;
    logic [15:0] r, rm;
    for (int i = 0; i < 5; i++) begin
      k = ms[i] ? 3 : 2;
      op16(ms[i], xs[i], lat, r, rm);
      tot_n++;
      if (lat !== lat_of(16, ms[i])) $display("FAIL lat16[%0d]: got %0d want %0d", i, lat, lat_of(16, ms[i]));
      else pass_n++;
      tot_n++;
      if (64'(r) !== mroot(64'(xs[i]), k)) $display("FAIL root16[%0d] x=%0d: got %0d want %0d", i, xs[i], r, mroot(64'(xs[i]), k));
      else pass_n++;
      tot_n++;
      if (64'(rm) !== 64'(xs[i]) - pw(mroot(64'(xs[i]), k), k)) $display("FAIL rem16[%0d] x=%0d: got %0d want %0d", i, xs[i], rm, 64'(xs[i]) - pw(mroot(64'(xs[i]), k), k));
      else pass_n++;
    end
  endtask
  task automatic test_start_ignored();
    int busy_n = 0, ready_n = 0;
    @(posedge clk); #1;
    b16.start = 1'b1; b16.mode = 1'b1; b16.x_in = 16'd1000;
    @(posedge clk); #1;
    b16.start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == 5) begin b16.start = 1'b1; b16.mode = 1'b0; b16.x_in = 16'd8; end
      if (c == 6) b16.start = 1'b0;
      busy_n += int'(b16.busy);
      ready_n += int'(b16.ready);
      @(posedge clk); #1;
    end
    tot_n++;
    if (busy_n !== 13) $display("FAIL ignore_busy: got %0d cycles want 13", busy_n);
    else pass_n++;
    tot_n++;
    if (ready_n !== 1) $display("FAIL ignore_ready: got %0d pulses want 1", ready_n);
    else pass_n++;
    tot_n++;
    if ({b16.root, b16.rem} !== {16'd10, 16'd0}) $display("FAIL ignore_result: got %0d/%0d want 10/0", b16.root, b16.rem);
    else pass_n++;
  endtask
  task automatic test_reset_mid();
    int ready_n = 0, lat;
    logic [15:0] r, rm;
    @(posedge clk); #1;
    b16.start = 1'b1; b16.mode = 1'b0; b16.x_in = 16'd50000;
    @(posedge clk); #1;
    b16.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    tot_n++;
    if ({b16.root, b16.rem, b16.busy, b16.ready} !== 34'd0) $display("FAIL midreset: got root=%0d rem=%0d busy=%b ready=%b want 0", b16.root, b16.rem, b16.busy, b16.ready);
    else pass_n++;
    rst = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      ready_n += int'(b16.ready);
    end
    tot_n++;
    if (ready_n !== 0) $display("FAIL midreset_ready: got %0d pulses want 0", ready_n);
    else pass_n++;
    op16(1'b0, 16'd50000, lat, r, rm);
    tot_n++;
    if ({r, rm} !== {16'(mroot(50000, 2)), 16'(50000 - pw(mroot(50000, 2), 2))}) $display("FAIL midreset_redo: got %0d/%0d want 223/271", r, rm);
    else pass_n++;
  endtask
  task automatic test_back_to_back();
    int seen = 0;
    int at [2] = '{-1, -1};
    logic [15:0] rr [2], rr_m [2];
    @(posedge clk); #1;
    b16.start = 1'b1; b16.mode = 1'b1; b16.x_in = 16'd8;
    @(posedge clk); #1;
    b16.mode = 1'b0; b16.x_in = 16'd100;
    for (int c = 1; c <= 60 && seen < 2; c++) begin
      @(posedge clk); #1;
      if (b16.ready) begin
        at[seen] = c; rr[seen] = b16.root; rr_m[seen] = b16.rem;
        seen++;
        if (seen == 2) b16.start = 1'b0;
      end
    end
    b16.start = 1'b0;
    tot_n++;
    if (at[0] !== lat_of(16, 1'b1)) $display("FAIL b2b_first_at: got %0d want %0d", at[0], lat_of(16, 1'b1));
    else pass_n++;
    tot_n++;
    if (at[1] !== at[0] + 1 + lat_of(16, 1'b0)) $display("FAIL b2b_second_at: got %0d want %0d", at[1], at[0] + 1 + lat_of(16, 1'b0));
    else pass_n++;
    tot_n++;
    if (seen == 2 && {rr[0], rr_m[0], rr[1], rr_m[1]} !== {16'(mroot(8, 3)), 16'd0, 16'(mroot(100, 2)), 16'd0})
      $display("FAIL b2b_results: got %0d/%0d %0d/%0d want 2/0 10/0", rr[0], rr_m[0], rr[1], rr_m[1]);
    else if (seen != 2) $display("FAIL b2b_results: got %0d pulses want 2", seen);
    else pass_n++;
    repeat (3) @(posedge clk);
  endtask
  task automatic test_w32();
    int lat, k;
    logic m;
    logic [31:0] x, r, rm;
    longint unsigned er;
    for (int i = 0; i < 14; i++) begin
      m = i == 0 ? 1'b1 : i == 1 ? 1'b0 : 1'($urandom_range(0, 1));
      x = i < 2 ? 32'hFFFF_FFFF : $urandom;
      k = m ? 3 : 2;
      er = mroot(64'(x), k);
      op32(m, x, lat, r, rm);
      tot_n++;
      if (lat !== lat_of(32, m)) $display("FAIL lat32[%0d]: got %0d want %0d", i, lat, lat_of(32, m));
      else pass_n++;
      tot_n++;
      if (64'(r) !== er || 64'(rm) !== 64'(x) - pw(er, k)) $display("FAIL res32[%0d] k=%0d x=%0d: got %0d/%0d want %0d/%0d", i, k, x, r, rm, er, 64'(x) - pw(er, k));
      else pass_n++;
      tot_n++;
      if (64'(rm) >= pw(64'(r) + 1, k) - pw(64'(r), k)) $display("FAIL bound32[%0d]: got rem %0d want below %0d", i, rm, pw(64'(r) + 1, k) - pw(64'(r), k));
      else pass_n++;
    end
  endtask
  task automatic test_random16();
    int lat, k;
    logic m;
    logic [15:0] x, r, rm;
    longint unsigned er;
    for (int i = 0; i < 12; i++) begin
      m = 1'($urandom_range(0, 1));
      x = 16'($urandom_range(0, 65535));
      k = m ? 3 : 2;
      er = mroot(64'(x), k);
      op16(m, x, lat, r, rm);
      tot_n++;
      if (lat !== lat_of(16, m) || 64'(r) !== er || 64'(rm) !== 64'(x) - pw(er, k))
        $display("FAIL rnd16[%0d] k=%0d x=%0d: got lat=%0d %0d/%0d want lat=%0d %0d/%0d", i, k, x, lat, r, rm, lat_of(16, m), er, 64'(x) - pw(er, k));
      else pass_n++;
    end
  endtask
  initial begin
    b16.start = 1'b0; b16.mode = 1'b0; b16.x_in = '0;
    b32.start = 1'b0; b32.mode = 1'b0; b32.x_in = '0;
    test_reset();
    test_basic16();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_w32();
    test_random16();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
